// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine for a 32x32 register file: walks the index range
// FIRST_REG..LAST_REG through one combinational read port and streams each
// captured word as an (index, data) beat on a valid/ready interface.
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_index,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  if (FIRST_REG < 0 || LAST_REG < FIRST_REG || LAST_REG > (2**ADDR_W) - 1) begin : g_bad_range
    $error("regfile_dump_reader: register range FIRST_REG..LAST_REG is invalid for ADDR_W");
  end

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_index_q, m_index_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;

  logic                beat_accepted;
  logic                beat_is_last;

  assign beat_accepted = m_valid_q && m_ready;
  assign beat_is_last  = (m_index_q == LAST_A);

  // State and datapath registers; reset clears the beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rf_addr_q <= FIRST_A;
      m_valid_q <= 1'b0;
      m_index_q <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rf_addr_q <= rf_addr_d;
      m_valid_q <= m_valid_d;
      m_index_q <= m_index_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  // Next-state: start is only honoured in IDLE, so a pulse while busy is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_READ;
      S_READ: state_d = S_SEND;
      S_SEND: if (beat_accepted) state_d = beat_is_last ? S_DONE : S_READ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture in READ, hold through SEND, advance on accept.
  always_comb begin
    rf_addr_d = rf_addr_q;
    m_valid_d = m_valid_q;
    m_index_d = m_index_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    unique case (state_q)
      S_IDLE: if (start) rf_addr_d = FIRST_A;
      S_READ: begin
        m_data_d  = rf_data;
        m_index_d = rf_addr_q;
        m_valid_d = 1'b1;
        m_last_d  = (rf_addr_q == LAST_A);
      end
      S_SEND: begin
        if (beat_accepted) begin
          m_valid_d = 1'b0;
          // The address stops at LAST_REG instead of incrementing, so it never wraps.
          if (beat_is_last) m_last_d = 1'b0;
          else              rf_addr_d = rf_addr_q + ADDR_W'(1);
        end
      end
      S_DONE: rf_addr_d = FIRST_A;
      default: ;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign rf_addr = rf_addr_q;
  assign m_valid = m_valid_q;
  assign m_index = m_index_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a full-range and a sub-range instance share a
// behavioural register file; beats are collected and compared to a snapshot model.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic [4:0]  a_rf_addr, b_rf_addr, a_idx, b_idx;
  logic [31:0] a_rf_data, b_rf_data, a_data, b_data;
  logic a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_done, b_done;

  logic [31:0] regs [32];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign a_rf_data = regs[a_rf_addr];
  assign b_rf_data = regs[b_rf_addr];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .rf_addr(a_rf_addr), .rf_data(a_rf_data),
    .m_valid(a_valid), .m_ready(ready_a), .m_index(a_idx), .m_data(a_data),
    .m_last(a_last), .busy(a_busy), .done(a_done)
  );

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(4), .LAST_REG(6)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .rf_addr(b_rf_addr), .rf_data(b_rf_data),
    .m_valid(b_valid), .m_ready(ready_b), .m_index(b_idx), .m_data(b_data),
    .m_last(b_last), .busy(b_busy), .done(b_done)
  );

  // Results of the most recent dump
  int          g_idx [$];
  logic [31:0] g_data [$];
  logic        g_last [$];
  logic [31:0] exp_mem [32];
  int done_cnt, done_cyc, first_valid_cyc, stable_err, timed_out, max_addr, busy_after_done, stall_held;

  task automatic preload_spec();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[4] = 32'hE;
    regs[5] = 32'h6;
    regs[6] = 32'hA;
  endtask

  // Drives one dump on the selected instance and records every accepted beat.
  // Expected data is the register file at start, updated only for writes to
  // indices the walk has not yet reached. Caller is aligned 1 time unit after posedge.
  task automatic run_dump(input int sel, input int first, input int last, input int rnd_ready,
                          input int stall_idx, input int stall_cyc, input int spam, input int wmode);
    int c, stall_left, held, w, idx, pi, addr;
    logic pv, pr, pl, v, l, d, b, rdy, st;
    logic [31:0] pd, dat, val;
    g_idx.delete(); g_data.delete(); g_last.delete();
    for (int i = 0; i < 32; i++) exp_mem[i] = regs[i];
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; stable_err = 0; timed_out = 0;
    max_addr = 0; busy_after_done = -1; stall_held = 0;
    stall_left = stall_cyc; pv = 1'b0; pr = 1'b0; pl = 1'b0; pi = 0; pd = '0;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (sel != 0) start_b = 1'b0; else start_a = 1'b0;
    c = 0;
    while (1) begin
      v    = (sel != 0) ? b_valid : a_valid;
      l    = (sel != 0) ? b_last  : a_last;
      d    = (sel != 0) ? b_done  : a_done;
      b    = (sel != 0) ? b_busy  : a_busy;
      idx  = int'((sel != 0) ? b_idx : a_idx);
      addr = int'((sel != 0) ? b_rf_addr : a_rf_addr);
      dat  = (sel != 0) ? b_data : a_data;
      if (addr > max_addr) max_addr = addr;
      if (v && first_valid_cyc < 0) first_valid_cyc = c;
      if (pv && !pr && !(v && idx == pi && dat == pd && l == pl)) stable_err++;
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after_done = int'(b);
      held = first + g_idx.size();
      rdy = (rnd_ready != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (v && held == stall_idx) begin
        stall_held++;
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end
      end
      if (v && rdy) begin
        g_idx.push_back(idx);
        g_data.push_back(dat);
        g_last.push_back(l);
      end
      if (v && wmode == 1 && $urandom_range(0, 1) == 1) begin
        w   = int'($urandom_range(0, 31));
        val = $urandom();
        regs[w] = val;
        if (w > held && w <= last) exp_mem[w] = val;
      end
      if (v && wmode == 2 && held == 5 && !rdy) regs[5] = 32'h55;
      st = (spam != 0 && done_cyc < 0 && $urandom_range(0, 2) == 0);
      if (sel != 0) begin ready_b = rdy; start_b = st; end
      else          begin ready_a = rdy; start_a = st; end
      pv = v; pr = rdy; pi = idx; pd = dat; pl = l;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      if (c >= 4000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    if (sel != 0) begin ready_b = 1'b0; start_b = 1'b0; end
    else          begin ready_a = 1'b0; start_a = 1'b0; end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #11;
    tests++; if (a_rf_addr !== 5'd0) begin fails++; $display("FAIL reset_a_rf_addr got %0d want 0", a_rf_addr); end
    tests++; if (b_rf_addr !== 5'd4) begin fails++; $display("FAIL reset_b_rf_addr got %0d want 4", b_rf_addr); end
    tests++; if ({a_valid, a_last, a_busy, a_done} !== 4'b0) begin fails++; $display("FAIL reset_a_flags got %b want 0000", {a_valid, a_last, a_busy, a_done}); end
    tests++; if ({b_valid, b_last, b_busy, b_done} !== 4'b0) begin fails++; $display("FAIL reset_b_flags got %b want 0000", {b_valid, b_last, b_busy, b_done}); end
    tests++; if (a_idx !== 5'd0 || a_data !== 32'h0) begin fails++; $display("FAIL reset_a_beat got idx %0d data %h want 0/0", a_idx, a_data); end
    tests++; if (b_idx !== 5'd0 || b_data !== 32'h0) begin fails++; $display("FAIL reset_b_beat got idx %0d data %h want 0/0", b_idx, b_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_dump();
    int bad;
    preload_spec();
    run_dump(0, 0, 31, 0, -1, 0, 0, 0);
    tests++; if (timed_out != 0) begin fails++; $display("FAIL full_timeout got %0d want 0", timed_out); end
    tests++; if (g_idx.size() != 32) begin fails++; $display("FAIL full_beats got %0d want 32", g_idx.size()); end
    bad = 0;
    foreach (g_idx[k]) if (g_idx[k] != k || g_data[k] !== exp_mem[k] || g_last[k] !== (k == 31)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL full_sequence got %0d bad beats want 0", bad); end
    if (g_idx.size() == 32) begin
      tests++; if (g_data[4] !== 32'h0000000E || g_data[5] !== 32'h00000006 || g_data[6] !== 32'h0000000A) begin
        fails++; $display("FAIL full_regs456 got %h %h %h want e 6 a", g_data[4], g_data[5], g_data[6]);
      end
    end
    tests++; if (first_valid_cyc != 1) begin fails++; $display("FAIL full_first_valid got %0d want 1", first_valid_cyc); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
    tests++; if (done_cyc != 64) begin fails++; $display("FAIL full_done_cycle got %0d want 64", done_cyc); end
    tests++; if (busy_after_done != 0) begin fails++; $display("FAIL full_idle_after got busy %0d want 0", busy_after_done); end
    tests++; if (max_addr != 31) begin fails++; $display("FAIL full_max_addr got %0d want 31", max_addr); end
  endtask

  task automatic test_subrange();
    preload_spec();
    run_dump(1, 4, 6, 0, -1, 0, 0, 0);
    tests++; if (g_idx.size() != 3) begin fails++; $display("FAIL sub_beats got %0d want 3", g_idx.size()); end
    if (g_idx.size() == 3) begin
      tests++; if (g_idx[0] != 4 || g_data[0] !== 32'hE) begin fails++; $display("FAIL sub_beat0 got (%0d,%h) want (4,e)", g_idx[0], g_data[0]); end
      tests++; if (g_idx[1] != 5 || g_data[1] !== 32'h6) begin fails++; $display("FAIL sub_beat1 got (%0d,%h) want (5,6)", g_idx[1], g_data[1]); end
      tests++; if (g_idx[2] != 6 || g_data[2] !== 32'hA) begin fails++; $display("FAIL sub_beat2 got (%0d,%h) want (6,a)", g_idx[2], g_data[2]); end
      tests++; if ({g_last[0], g_last[1], g_last[2]} !== 3'b001) begin fails++; $display("FAIL sub_last got %b want 001", {g_last[0], g_last[1], g_last[2]}); end
    end
    tests++; if (done_cnt != 1 || done_cyc != 6) begin fails++; $display("FAIL sub_done got count %0d cycle %0d want 1/6", done_cnt, done_cyc); end
    tests++; if (max_addr != 6) begin fails++; $display("FAIL sub_max_addr got %0d want 6", max_addr); end
  endtask

  task automatic test_backpressure();
    int bad;
    preload_spec();
    run_dump(0, 0, 31, 0, 5, 5, 0, 0);
    tests++; if (stable_err != 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", stable_err); end
    tests++; if (stall_held != 6) begin fails++; $display("FAIL bp_held_cycles got %0d want 6", stall_held); end
    bad = 0;
    foreach (g_idx[k]) if (g_idx[k] != k || g_data[k] !== exp_mem[k]) bad++;
    tests++; if (g_idx.size() != 32 || bad != 0) begin fails++; $display("FAIL bp_sequence got %0d beats %0d bad want 32/0", g_idx.size(), bad); end
    tests++; if (done_cnt != 1 || done_cyc != 69) begin fails++; $display("FAIL bp_done got count %0d cycle %0d want 1/69", done_cnt, done_cyc); end
  endtask

  task automatic test_restart_ignored();
    int bad;
    preload_spec();
    run_dump(0, 0, 31, 0, -1, 0, 1, 0);
    bad = 0;
    foreach (g_idx[k]) if (g_idx[k] != k) bad++;
    tests++; if (g_idx.size() != 32 || bad != 0) begin fails++; $display("FAIL restart_sequence got %0d beats %0d bad want 32/0", g_idx.size(), bad); end
    tests++; if (done_cnt != 1 || done_cyc != 64) begin fails++; $display("FAIL restart_done got count %0d cycle %0d want 1/64", done_cnt, done_cyc); end
  endtask

  task automatic test_reset_mid_dump();
    int found;
    preload_spec();
    found = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    ready_a = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (a_valid && a_idx == 5'd10) begin
        ready_a = 1'b0;
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    tests++; if (found != 1) begin fails++; $display("FAIL rstmid_reach10 got %0d want 1", found); end
    @(posedge clk); #1;
    tests++; if (!(a_valid === 1'b1 && a_idx === 5'd10)) begin fails++; $display("FAIL rstmid_hold got valid %b idx %0d want 1/10", a_valid, a_idx); end
    #2 rst = 1'b1;
    #1;
    tests++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin fails++; $display("FAIL rstmid_async got valid %b busy %b want 0/0", a_valid, a_busy); end
    tests++; if (a_rf_addr !== 5'd0 || a_done !== 1'b0) begin fails++; $display("FAIL rstmid_addr got addr %0d done %b want 0/0", a_rf_addr, a_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin fails++; $display("FAIL rstmid_no_done got done %b busy %b want 0/0", a_done, a_busy); end
    run_dump(0, 0, 31, 0, -1, 0, 0, 0);
    tests++; if (g_idx.size() != 32 || g_idx[0] != 0) begin fails++; $display("FAIL rstmid_redump got %0d beats want 32 from 0", g_idx.size()); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL rstmid_redump_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_write_during_send();
    preload_spec();
    run_dump(0, 0, 31, 0, 5, 3, 0, 2);
    tests++; if (g_idx.size() != 32 || g_data[5] !== 32'h6) begin fails++; $display("FAIL wsend_held got %0d beats data5 %h want 32/6", g_idx.size(), (g_data.size() > 5) ? g_data[5] : 32'hX); end
    tests++; if (regs[5] !== 32'h55) begin fails++; $display("FAIL wsend_write_applied got %h want 55", regs[5]); end
    run_dump(0, 0, 31, 0, -1, 0, 0, 0);
    tests++; if (g_idx.size() != 32 || g_data[5] !== 32'h55) begin fails++; $display("FAIL wsend_second got %0d beats data5 %h want 32/55", g_idx.size(), (g_data.size() > 5) ? g_data[5] : 32'hX); end
  endtask

  task automatic test_random();
    int sel, first, last, bad;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      sel   = it % 2;
      first = (sel != 0) ? 4 : 0;
      last  = (sel != 0) ? 6 : 31;
      run_dump(sel, first, last, 1, -1, 0, 1, 1);
      bad = 0;
      foreach (g_idx[k]) if (g_idx[k] != first + k || g_data[k] !== exp_mem[first + k] || g_last[k] !== (k == last - first)) bad++;
      tests++; if (g_idx.size() != last - first + 1 || bad != 0) begin fails++; $display("FAIL rand%0d_sequence got %0d beats %0d bad want %0d/0", it, g_idx.size(), bad, last - first + 1); end
      tests++; if (done_cnt != 1 || timed_out != 0) begin fails++; $display("FAIL rand%0d_done got count %0d timeout %0d want 1/0", it, done_cnt, timed_out); end
      tests++; if (stable_err != 0) begin fails++; $display("FAIL rand%0d_stable got %0d changes want 0", it, stable_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_full_dump();
    test_subrange();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_dump();
    test_write_during_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
